// File: rtl/div_counter_pkg.sv
// Shared limits, types and helpers for the rate-divided up/down counter.
package div_counter_pkg;

    localparam int unsigned WIDTH_MIN  = 2;
    localparam int unsigned WIDTH_MAX  = 16;
    localparam int unsigned SET_W_MIN  = 1;
    localparam int unsigned SET_W_MAX  = 3;
    localparam int unsigned CY_DLY_MIN = 1;
    localparam int unsigned CY_DLY_MAX = 8;

    // Synchronised single-bit controls travel together through one synchroniser.
    typedef struct packed {
        logic ld;
        logic up;
        logic en;
    } ctrl_t;

    function automatic int unsigned ratio_from_set(input logic [SET_W_MAX-1:0] set);
        return 32'd1 << set;
    endfunction

    function automatic int unsigned pre_width(input int unsigned set_w);
        return (32'd1 << set_w) - 32'd1;
    endfunction

endpackage

// File: rtl/div_counter_n_if.sv
// Control inputs and counter outputs of div_counter_n, grouped as one bus.
interface div_counter_n_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SET_W = 2
);

    logic             ld;
    logic [WIDTH-1:0] di;
    logic [SET_W-1:0] clk_set;
    logic             up;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             cy;
    logic             tick;

    modport master (output ld, di, clk_set, up, en, input q, cy, tick);
    modport slave  (input ld, di, clk_set, up, en, output q, cy, tick);

endinterface

// File: rtl/div_counter_n_sync2.sv
// Two-flop synchroniser for an asynchronous input group.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // NOTE: non-blocking assignments let both flops sample their inputs before either updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/div_counter_n.sv
// Up/down counter advancing once every 2^clk_set cycles, with a delayed carry/borrow pulse.
module div_counter_n
    import div_counter_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SET_W  = 2,
    parameter int unsigned CY_DLY = 2
) (
    input logic            clk_sys,
    input logic            rst,
    div_counter_n_if.slave bus
);

    localparam int unsigned PRE_W = pre_width(SET_W);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || SET_W < SET_W_MIN || SET_W > SET_W_MAX ||
        CY_DLY < CY_DLY_MIN || CY_DLY > CY_DLY_MAX) begin : g_param_check
        $error("div_counter_n: parameter out of range");
    end

    ctrl_t            ctrl_s;
    logic [WIDTH-1:0] di_s;
    logic [SET_W-1:0] set_s;

    sync2 #(.W($bits(ctrl_t))) u_sync_ctrl (
        .clk  (clk_sys),
        .rst_n(rst),
        .d_i  ({bus.ld, bus.up, bus.en}),
        .q_o  (ctrl_s)
    );

    sync2 #(.W(WIDTH)) u_sync_di (
        .clk  (clk_sys),
        .rst_n(rst),
        .d_i  (bus.di),
        .q_o  (di_s)
    );

    sync2 #(.W(SET_W)) u_sync_set (
        .clk  (clk_sys),
        .rst_n(rst),
        .d_i  (bus.clk_set),
        .q_o  (set_s)
    );

    logic [SET_W-1:0]  set_prev_q;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [PRE_W-1:0]  pre_last;
    logic              set_chg;
    logic              tick_q, tick_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              cy_raw_q, cy_raw_d;
    logic [CY_DLY-1:0] cy_sh_q, cy_sh_d;

    assign pre_last = PRE_W'(ratio_from_set(SET_W_MAX'(set_s)) - 32'd1);
    assign set_chg  = (set_s != set_prev_q);

    // A rate change restarts the period so the new ratio starts from a clean phase.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pre_d  = pre_q + PRE_W'(1);
        tick_d = 1'b0;
        if (set_chg) begin
            pre_d = '0;
        end else if (pre_q == pre_last) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_comb begin
        q_d      = q_q;
        cy_raw_d = 1'b0;
        if (tick_q) begin
            if (ctrl_s.ld) begin
                q_d = di_s;
            end else if (ctrl_s.en) begin
                if (ctrl_s.up) begin
                    q_d      = q_q + WIDTH'(1);
                    cy_raw_d = &q_q;
                end else begin
                    q_d      = q_q - WIDTH'(1);
                    cy_raw_d = ~|q_q;
                end
            end
        end
    end

    // Bit 0 takes the fresh carry; the top bit is the outgoing delayed pulse.
    assign cy_sh_d = CY_DLY'({cy_sh_q, cy_raw_q});

    always_ff @(posedge clk_sys or negedge rst) begin
        if (!rst) begin
            set_prev_q <= '0;
            pre_q      <= '0;
            tick_q     <= 1'b0;
            q_q        <= '0;
            cy_raw_q   <= 1'b0;
            cy_sh_q    <= '0;
        end else begin
            set_prev_q <= set_s;
            pre_q      <= pre_d;
            tick_q     <= tick_d;
            q_q        <= q_d;
            cy_raw_q   <= cy_raw_d;
            cy_sh_q    <= cy_sh_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.tick = tick_q;
    assign bus.cy   = cy_sh_q[CY_DLY-1];

endmodule

// File: tb/tb_div_counter_n.sv
// Randomised bench for div_counter_n against a cycle-count reference model.
module tb_div_counter_n;

    localparam int unsigned W      = 4;
    localparam int unsigned SW     = 2;
    localparam int unsigned CY_DLY = 2;

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    div_counter_n_if #(.WIDTH(W), .SET_W(SW)) bus ();

    div_counter_n #(.WIDTH(W), .SET_W(SW), .CY_DLY(CY_DLY)) dut (
        .clk_sys(clk_sys),
        .rst    (rst),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: inputs seen two edges late, ticks from edge count since the last rate change.
    typedef struct packed {
        logic          ld;
        logic [W-1:0]  di;
        logic [SW-1:0] set;
        logic          up;
        logic          en;
    } in_t;

    in_t           hist[$];
    bit            cyq[$];
    int unsigned   k, seg;
    logic [SW-1:0] last_set;
    logic [W-1:0]  m_q;
    logic          m_tick, m_cy;

    always @(posedge clk_sys or negedge rst) begin
        in_t s;
        in_t cur;
        bit  wrap;
        if (!rst) begin
            k = 0; seg = 0; last_set = '0; m_q = '0; m_tick = 1'b0; m_cy = 1'b0;
            hist.delete(); hist.push_back('0); hist.push_back('0);
            cyq.delete();
            for (int i = 0; i < int'(CY_DLY); i++) cyq.push_back(1'b0);
        end else begin
            k++;
            cur.ld = bus.ld; cur.di = bus.di; cur.set = bus.clk_set; cur.up = bus.up; cur.en = bus.en;
            s = hist.pop_front();
            hist.push_back(cur);
            wrap = 1'b0;
            if (m_tick) begin
                if (s.ld) m_q = s.di;
                else if (s.en && s.up) begin wrap = (m_q == {W{1'b1}}); m_q = m_q + 1'b1; end
                else if (s.en) begin wrap = (m_q == '0); m_q = m_q - 1'b1; end
            end
            cyq.push_back(wrap);
            m_cy = cyq.pop_front();
            if (s.set != last_set) begin
                seg = k; last_set = s.set; m_tick = 1'b0;
            end else begin
                m_tick = (((k - seg) % (32'd1 << s.set)) == 0);
            end
        end
    end

    task automatic drive_idle(input logic [SW-1:0] set);
        bus.ld = 1'b0; bus.di = '0; bus.clk_set = set; bus.up = 1'b1; bus.en = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_sys);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.q, bus.tick, bus.cy} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got q=%h tick=%b cy=%b, want all 0", bus.q, bus.tick, bus.cy);
        end
        for (int i = 0; i < 4; i++) begin
            bus.ld = 1'($urandom()); bus.di = W'($urandom()); bus.clk_set = SW'($urandom());
            bus.up = 1'($urandom()); bus.en = 1'($urandom());
            @(negedge clk_sys);
            n_tests++;
            if ({bus.q, bus.tick, bus.cy} !== '0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: got q=%h tick=%b cy=%b, want all 0", i, bus.q, bus.tick, bus.cy);
            end
        end
        drive_idle(2'd0);
        @(negedge clk_sys);
        rst = 1'b1;
    endtask

    task automatic test_count_up();
        int wrap_at = -1, cy_at = -1, cy_cnt = 0;
        logic [W-1:0] prev_q = '0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge clk_sys);
            n_tests++;
            if ({bus.q, bus.tick, bus.cy} !== {m_q, m_tick, m_cy}) begin
                n_fail++;
                $display("FAIL count_up_model[%0d]: got q=%h tick=%b cy=%b, want q=%h tick=%b cy=%b",
                         i, bus.q, bus.tick, bus.cy, m_q, m_tick, m_cy);
            end
            if (i <= 17) begin
                n_tests++;
                if (bus.q !== W'((i < 2) ? 0 : i - 2)) begin
                    n_fail++;
                    $display("FAIL count_up_seq[%0d]: got q=%h want %h", i, bus.q, W'((i < 2) ? 0 : i - 2));
                end
            end
            if (prev_q == 4'hF && bus.q == 4'h0 && wrap_at < 0) wrap_at = i;
            if (bus.cy === 1'b1) begin cy_cnt++; if (cy_at < 0) cy_at = i; end
            prev_q = bus.q;
        end
        n_tests++;
        if (cy_cnt != 1 || cy_at - wrap_at != int'(CY_DLY)) begin
            n_fail++;
            $display("FAIL count_up_cy: got %0d pulses, delay %0d, want 1 pulse delay %0d",
                     cy_cnt, cy_at - wrap_at, CY_DLY);
        end
    endtask

    task automatic test_div4();
        int t_cnt = 0, cy_cnt = 0, waited = 0;
        @(negedge clk_sys);
        rst = 1'b0;
        drive_idle(2'd2);
        @(negedge clk_sys);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) @(negedge clk_sys);
        while (bus.tick !== 1'b1 && waited < 20) begin
            @(negedge clk_sys);
            waited++;
        end
        n_tests++;
        if (waited >= 20) begin
            n_fail++;
            $display("FAIL div4_first_tick: got no tick in 20 cycles, want tick");
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_sys);
            n_tests++;
            if ({bus.q, bus.tick, bus.cy} !== {m_q, m_tick, m_cy}) begin
                n_fail++;
                $display("FAIL div4_model[%0d]: got q=%h tick=%b cy=%b, want q=%h tick=%b cy=%b",
                         i, bus.q, bus.tick, bus.cy, m_q, m_tick, m_cy);
            end
            if (bus.tick === 1'b1) t_cnt++;
            if (bus.cy === 1'b1) cy_cnt++;
        end
        n_tests++;
        if (t_cnt != 16 || cy_cnt != 1) begin
            n_fail++;
            $display("FAIL div4_counts: got ticks=%0d cy=%0d, want ticks=16 cy=1", t_cnt, cy_cnt);
        end
    endtask

    task automatic test_load_down();
        int cy_cnt = 0;
        bus.clk_set = 2'd0;
        for (int i = 0; i < 10; i++) @(negedge clk_sys);
        bus.ld = 1'b1; bus.di = 4'hA;
        @(negedge clk_sys);
        bus.ld = 1'b0; bus.up = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);
        n_tests++;
        if (bus.q !== 4'hA) begin
            n_fail++;
            $display("FAIL load_value: got q=%h want a", bus.q);
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_sys);
            n_tests++;
            if ({bus.q, bus.tick, bus.cy} !== {m_q, m_tick, m_cy}) begin
                n_fail++;
                $display("FAIL load_down_model[%0d]: got q=%h tick=%b cy=%b, want q=%h tick=%b cy=%b",
                         i, bus.q, bus.tick, bus.cy, m_q, m_tick, m_cy);
            end
            if (bus.cy === 1'b1) cy_cnt++;
        end
        n_tests++;
        if (cy_cnt != 1) begin
            n_fail++;
            $display("FAIL load_down_borrow: got %0d pulses want 1", cy_cnt);
        end
    endtask

    task automatic test_rate_change();
        int waited = 0, first = -1, second = -1;
        bus.up = 1'b1; bus.clk_set = 2'd3;
        for (int i = 0; i < 12; i++) @(negedge clk_sys);
        while (bus.tick !== 1'b1 && waited < 20) begin
            @(negedge clk_sys);
            waited++;
        end
        repeat ($urandom_range(3, 1)) @(negedge clk_sys);
        bus.clk_set = 2'd1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_sys);
            n_tests++;
            if ({bus.q, bus.tick, bus.cy} !== {m_q, m_tick, m_cy}) begin
                n_fail++;
                $display("FAIL rate_change_model[%0d]: got q=%h tick=%b cy=%b, want q=%h tick=%b cy=%b",
                         i, bus.q, bus.tick, bus.cy, m_q, m_tick, m_cy);
            end
            if (bus.tick === 1'b1) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        n_tests++;
        if (first != 5 || second != 7) begin
            n_fail++;
            $display("FAIL rate_change_ticks: got ticks at %0d,%0d want 5,7", first, second);
        end
    endtask

    task automatic test_hold_load();
        logic [W-1:0] held;
        logic [W-1:0] val;
        int t_cnt = 0, waited = 0;
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk_sys);
        held = bus.q;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk_sys);
            if (bus.tick === 1'b1) t_cnt++;
            n_tests++;
            if (bus.q !== held || bus.q !== m_q) begin
                n_fail++;
                $display("FAIL hold[%0d]: got q=%h want %h", i, bus.q, held);
            end
        end
        n_tests++;
        if (t_cnt < 10) begin
            n_fail++;
            $display("FAIL hold_ticks: got %0d ticks want at least 10", t_cnt);
        end
        val = W'($urandom());
        bus.di = val; bus.ld = 1'b1;
        while (bus.q !== val && waited < 8) begin
            @(negedge clk_sys);
            waited++;
        end
        n_tests++;
        if (bus.q !== val) begin
            n_fail++;
            $display("FAIL load_no_en: got q=%h want %h", bus.q, val);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            n_tests++;
            if (bus.q !== val) begin
                n_fail++;
                $display("FAIL load_held[%0d]: got q=%h want %h", i, bus.q, val);
            end
        end
        bus.ld = 1'b0; bus.en = 1'b1;
    endtask

    task automatic test_reset_after_wrap();
        logic [W-1:0] prev_q;
        int waited = 0, cy_seen = 0;
        bus.clk_set = 2'd0; bus.up = 1'b1; bus.en = 1'b1; bus.ld = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk_sys);
        prev_q = bus.q;
        @(negedge clk_sys);
        while (!(prev_q == 4'hF && bus.q == 4'h0) && waited < 80) begin
            prev_q = bus.q;
            @(negedge clk_sys);
            waited++;
        end
        n_tests++;
        if (waited >= 80) begin
            n_fail++;
            $display("FAIL wrap_wait: got no wrap in 80 cycles, want wrap");
        end
        @(negedge clk_sys);
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.q, bus.tick, bus.cy} !== '0) begin
            n_fail++;
            $display("FAIL rst_wrap_async: got q=%h tick=%b cy=%b, want all 0", bus.q, bus.tick, bus.cy);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (i == 4) rst = 1'b1;
            if (bus.cy === 1'b1) cy_seen++;
            if (i < 4) begin
                n_tests++;
                if ({bus.q, bus.tick, bus.cy} !== '0) begin
                    n_fail++;
                    $display("FAIL rst_wrap_hold[%0d]: got q=%h tick=%b cy=%b, want all 0", i, bus.q, bus.tick, bus.cy);
                end
            end
        end
        n_tests++;
        if (cy_seen != 0) begin
            n_fail++;
            $display("FAIL rst_wrap_cy: got %0d cy pulses want 0", cy_seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            n_tests++;
            if ({bus.q, bus.tick, bus.cy} !== {m_q, m_tick, m_cy}) begin
                n_fail++;
                $display("FAIL random_model[%0d]: got q=%h tick=%b cy=%b, want q=%h tick=%b cy=%b",
                         i, bus.q, bus.tick, bus.cy, m_q, m_tick, m_cy);
            end
            bus.ld = ($urandom_range(15) == 0);
            bus.di = W'($urandom());
            if ($urandom_range(7) == 0) bus.up = ~bus.up;
            bus.en = ($urandom_range(7) != 0);
            if ($urandom_range(39) == 0) bus.clk_set = SW'($urandom());
        end
        drive_idle(2'd0);
    endtask

    initial begin
        drive_idle(2'd0);
        #1 rst = 1'b0;
        test_reset();
        test_count_up();
        test_div4();
        test_load_down();
        test_rate_change();
        test_hold_load();
        test_reset_after_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
